fifo_write_handler: RTL

Write-side pointer and flag logic for the depth-90 FIFO. Accepts write requests, drives the storage RAM write port, and advances a wrap-bit write pointer that the read handler consumes as `wrPtr`. It takes the read handler's `rdPtr` back to generate full, almost-full, fill level and a sticky overflow error. It shares the read handler's pointer encoding: the MSB is the wrap bit, and the low bits are a modulo-`depth` index.

---
 rtl/fifo_write_handler.sv | 46 ++++
 1 files changed

// File: rtl/fifo_write_handler.sv
// fifo_write_handler: write pointer, RAM write port and full/level/overflow flags for a FIFO of arbitrary depth.
module fifo_write_handler #(
  parameter int d = 8,
  parameter int depth = 90,
  parameter int w = 8,
  parameter int afull_lvl = 80
) (
  input  logic         wrclk,
  input  logic         wrrst,
  input  logic         wren,
  input  logic [w-1:0] din,
  input  logic [d-1:0] rdPtr,
  output logic [d-1:0] wrPtr,
  output logic         fifo_full,
  output logic         almost_full,
  output logic [d-1:0] level,
  output logic         mem_we,
  output logic [d-2:0] mem_waddr,
  output logic [w-1:0] mem_wdata,
  output logic         overflow
);
  logic [d-2:0] wi, ri;
  logic [d-1:0] nxt;
  assign wi = wrPtr[d-2:0];
  assign ri = rdPtr[d-2:0];
  assign fifo_full = (wrPtr[d-1] != rdPtr[d-1]) && (wi == ri);
  // Modulo-2^d arithmetic matches a d+1-bit computation truncated to d bits.
  assign level = (wrPtr[d-1] == rdPtr[d-1]) ? {1'b0, wi} - {1'b0, ri}
                                            : d'(depth) - {1'b0, ri} + {1'b0, wi};
  assign almost_full = level >= d'(afull_lvl);
  assign mem_we = wren && !fifo_full;
  assign mem_waddr = wi;
  assign mem_wdata = din;
  assign nxt = (wi < (d-1)'(depth - 1)) ? {wrPtr[d-1], wi + (d-1)'(1)}
             : (wi == (d-1)'(depth - 1)) ? {~wrPtr[d-1], {(d-1){1'b0}}}
             : wrPtr;
  always_ff @(posedge wrclk) begin
    if (wrrst) begin
      wrPtr <= '0;
      overflow <= 1'b0;
    end else begin
      if (mem_we) wrPtr <= nxt;
      if (wren && fifo_full) overflow <= 1'b1;
    end
  end
endmodule
